// File: rtl/coprocessor_seq_pkg.sv
// Shared types and bit positions for the coprocessor sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package coprocessor_seq_pkg;

    // Encoding is visible to software through status[2:0].
    typedef enum logic [2:0] {
        ST_HOLD   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_RUN    = 3'd3,
        ST_TO_RST = 3'd4
    } state_e;

    // Control word bit positions (from the Nios control PIO).
    localparam int CTRL_RST     = 0;
    localparam int CTRL_START   = 1;
    localparam int CTRL_IRQEN   = 2;
    localparam int CTRL_MODE_LO = 3;

    // Status word bit positions (to the read-only input PIO).
    localparam int STS_STATE_LO = 0;
    localparam int STS_BUSY     = 3;
    localparam int STS_DONE     = 4;
    localparam int STS_ERROR    = 5;
    localparam int STS_TIMEOUT  = 6;
    localparam int STS_OVERRUN  = 7;
    localparam int STS_CNT_LO   = 8;

endpackage

// File: rtl/coprocessor_seq_timer.sv
// Shared load/increment/decrement counter with an equality compare against cmp_val.
// Latency: count updates one cycle after load/inc/dec; at_cmp is combinational on the count.
// Backpressure: none; load has priority over inc, inc over dec.
// Ports: clk, reset_n, load/load_val, inc, dec, cmp_val -> at_cmp.
module coprocessor_seq_timer #(
    parameter int CNT_W   = 20,
    parameter int RST_VAL = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    input  logic [CNT_W-1:0] cmp_val,
    output logic             at_cmp
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= CNT_W'(RST_VAL);
        end else if (load) begin
            cnt_q <= load_val;
        end else if (inc) begin
            cnt_q <= cnt_q + ONE;
        end else if (dec) begin
            cnt_q <= cnt_q - ONE;
        end
    end

    assign at_cmp = (cnt_q == cmp_val);

endmodule

// File: rtl/coprocessor_seq_ctrl.sv
// Sequences coprocessor reset/start/done/timeout from the 6-bit PIO control word; reports a 16-bit status and level IRQ.
// Latency: all outputs registered; cop_start pulses the cycle after a start edge is sampled in IDLE.
// Backpressure: none; start edges outside IDLE are dropped and flagged as overrun (silently dropped in HOLD).
// Ports: clk, reset_n, ctrl_in[5:0], cop_busy/cop_done/cop_error in; cop_reset_n, cop_start, cop_mode[2:0], status[15:0], irq out.
module coprocessor_seq_ctrl
    import coprocessor_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int RST_STRETCH    = 8,
    parameter int CNT_W          = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  ctrl_in,
    input  logic        cop_busy,
    input  logic        cop_done,
    input  logic        cop_error,
    output logic        cop_reset_n,
    output logic        cop_start,
    output logic [2:0]  cop_mode,
    output logic [15:0] status,
    output logic        irq
);

    state_e     state_q, state_d;
    logic       start_q;            // only the start bit of the delayed control word is ever used
    logic [2:0] mode_q, mode_d;
    logic       done_q, done_d;
    logic       error_q, error_d;
    logic       timeout_q, timeout_d;
    logic       overrun_q, overrun_d;
    logic [7:0] cnt_q, cnt_d;
    logic       busy_q;
    logic       cop_reset_n_q;
    logic       cop_start_q;
    logic       irq_q;

    logic             t_load, t_inc, t_dec, t_at;
    logic [CNT_W-1:0] t_load_val, t_cmp;

    logic rst_req, start_edge;
    assign rst_req    = ctrl_in[CTRL_RST];
    assign start_edge = ctrl_in[CTRL_START] & ~start_q;

    coprocessor_seq_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (RST_STRETCH)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (t_load),
        .load_val (t_load_val),
        .inc      (t_inc),
        .dec      (t_dec),
        .cmp_val  (t_cmp),
        .at_cmp   (t_at)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        done_d     = done_q;
        error_d    = error_q;
        timeout_d  = timeout_q;
        overrun_d  = overrun_q;
        cnt_d      = cnt_q;
        t_load     = 1'b0;
        t_load_val = CNT_W'(RST_STRETCH);
        t_inc      = 1'b0;
        t_dec      = 1'b0;
        // Counting down states exit at 1; RUN compares against the timeout threshold.
        t_cmp      = (state_q == ST_RUN) ? CNT_W'(TIMEOUT_CYCLES - 1) : CNT_W'(1);

        if (rst_req) begin
            // Reset request beats done, timeout and start; an in-flight run is dropped untouched.
            state_d = ST_HOLD;
            t_load  = 1'b1;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (t_at) state_d = ST_IDLE;
                    else      t_dec   = 1'b1;
                end
                ST_IDLE: begin
                    if (start_edge) begin
                        state_d   = ST_LAUNCH;
                        mode_d    = ctrl_in[CTRL_MODE_LO +: 3];
                        done_d    = 1'b0;
                        error_d   = 1'b0;
                        timeout_d = 1'b0;
                        overrun_d = 1'b0;
                    end
                end
                ST_LAUNCH: begin
                    state_d    = ST_RUN;
                    t_load     = 1'b1;
                    t_load_val = '0;
                    if (start_edge) overrun_d = 1'b1;
                end
                ST_RUN: begin
                    if (start_edge) overrun_d = 1'b1;
                    // Done is checked first so a completion on the threshold cycle is not a timeout.
                    if (cop_done) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        if (cop_error) error_d = 1'b1;
                        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                    end else if (t_at) begin
                        state_d   = ST_TO_RST;
                        timeout_d = 1'b1;
                        t_load    = 1'b1;
                    end else begin
                        t_inc = 1'b1;
                    end
                end
                ST_TO_RST: begin
                    if (start_edge) overrun_d = 1'b1;
                    if (t_at) state_d = ST_IDLE;
                    else      t_dec   = 1'b1;
                end
                default: state_d = ST_HOLD;
            endcase
        end

        if (state_d == ST_HOLD) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_HOLD;
            start_q       <= 1'b0;
            mode_q        <= '0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            timeout_q     <= 1'b0;
            overrun_q     <= 1'b0;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            cop_reset_n_q <= 1'b0;
            cop_start_q   <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= ctrl_in[CTRL_START];
            mode_q        <= mode_d;
            done_q        <= done_d;
            error_q       <= error_d;
            timeout_q     <= timeout_d;
            overrun_q     <= overrun_d;
            cnt_q         <= cnt_d;
            busy_q        <= cop_busy;
            cop_reset_n_q <= (state_d != ST_HOLD) && (state_d != ST_TO_RST);
            cop_start_q   <= (state_d == ST_LAUNCH);
            irq_q         <= ctrl_in[CTRL_IRQEN] & (done_q | error_q | timeout_q);
        end
    end

    always_comb begin
        status                          = '0;
        status[STS_STATE_LO +: 3]       = state_q;
        status[STS_BUSY]                = busy_q;
        status[STS_DONE]                = done_q;
        status[STS_ERROR]               = error_q;
        status[STS_TIMEOUT]             = timeout_q;
        status[STS_OVERRUN]             = overrun_q;
        status[STS_CNT_LO +: 8]         = cnt_q;
    end

    assign cop_reset_n = cop_reset_n_q;
    assign cop_start   = cop_start_q;
    assign cop_mode    = mode_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_coprocessor_seq_ctrl.sv
// Scoreboard bench for coprocessor_seq_ctrl: directed stimulus pushes expected events,
// a negedge monitor pops and compares on every status change, start pulse, reset release and irq change.
module tb_coprocessor_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  ctrl_in;
    logic        cop_busy, cop_done, cop_error;
    logic        cop_reset_n, cop_start, irq;
    logic [2:0]  cop_mode;
    logic [15:0] status;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_status[$];
    logic [2:0]  exp_mode[$];
    int          exp_rlow[$];
    logic        exp_irq[$];

    always #5 clk = ~clk;

    coprocessor_seq_ctrl #(
        .TIMEOUT_CYCLES (16),
        .RST_STRETCH    (4),
        .CNT_W          (20)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ctrl_in     (ctrl_in),
        .cop_busy    (cop_busy),
        .cop_done    (cop_done),
        .cop_error   (cop_error),
        .cop_reset_n (cop_reset_n),
        .cop_start   (cop_start),
        .cop_mode    (cop_mode),
        .status      (status),
        .irq         (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected output 0x%0h at %0t", name, act, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every observable output event consumes one expectation.
    logic [15:0] prev_status = 16'h0000;
    logic        prev_start  = 1'b0;
    logic        prev_rstn   = 1'b0;
    logic        prev_irq    = 1'b0;
    int          low_cnt     = 0;

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (status !== prev_status) begin
                if (exp_status.size() == 0) unexpected("status", 32'(status));
                else check("status", 32'(status), 32'(exp_status.pop_front()));
                prev_status = status;
            end
            if (cop_start === 1'b1) begin
                if (prev_start === 1'b1) unexpected("start_width", 32'(cop_start));
                if (exp_mode.size() == 0) unexpected("cop_start", 32'(cop_mode));
                else check("cop_mode", 32'(cop_mode), 32'(exp_mode.pop_front()));
            end
            prev_start = cop_start;
            // Count reset-low cycles only after software has released its request.
            if (cop_reset_n === 1'b0 && ctrl_in[0] === 1'b0) low_cnt++;
            if (cop_reset_n === 1'b1 && prev_rstn === 1'b0) begin
                if (exp_rlow.size() == 0) unexpected("rst_release", 32'(low_cnt));
                else check("rst_low_cycles", 32'(low_cnt), 32'(exp_rlow.pop_front()));
                low_cnt = 0;
            end
            prev_rstn = cop_reset_n;
            if (irq !== prev_irq) begin
                if (exp_irq.size() == 0) unexpected("irq", 32'(irq));
                else check("irq", 32'(irq), 32'(exp_irq.pop_front()));
                prev_irq = irq;
            end
        end
    end

    initial begin
        int c, c2;
        reset_n   = 1'b0;
        ctrl_in   = 6'h01;
        cop_busy  = 1'b0;
        cop_done  = 1'b0;
        cop_error = 1'b0;
        repeat (3) tick();
        check("rst_status", 32'(status), 32'h0000);
        check("rst_cop_reset_n", 32'(cop_reset_n), 32'h0);
        check("rst_cop_start", 32'(cop_start), 32'h0);
        check("rst_cop_mode", 32'(cop_mode), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        tick();
        tick();

        // Leave HOLD: 4 stretch cycles then IDLE.
        exp_status.push_back(16'h0001);
        exp_rlow.push_back(4);
        ctrl_in = 6'h00;
        repeat (6) tick();

        // Start with mode 3, busy while running, done after 5 cycles.
        exp_status.push_back(16'h0002);
        exp_status.push_back(16'h000B);
        exp_status.push_back(16'h0111);
        exp_mode.push_back(3'd3);
        ctrl_in = 6'h1A;
        tick();
        cop_busy = 1'b1;
        repeat (4) tick();
        cop_busy = 1'b0;
        cop_done = 1'b1;
        tick();
        cop_done = 1'b0;
        exp_irq.push_back(1'b1);
        ctrl_in = 6'h1E;
        tick();
        ctrl_in = 6'h04;
        tick();

        // Start with no completion: timeout after 16 RUN cycles, 4-cycle recovery reset.
        exp_status.push_back(16'h0102);
        exp_status.push_back(16'h0103);
        exp_status.push_back(16'h0144);
        exp_status.push_back(16'h0141);
        exp_mode.push_back(3'd0);
        exp_irq.push_back(1'b0);
        exp_irq.push_back(1'b1);
        exp_rlow.push_back(4);
        ctrl_in = 6'h06;
        repeat (25) tick();

        // Overrun from a second edge in RUN, then done with error.
        ctrl_in = 6'h04;
        tick();
        exp_status.push_back(16'h0102);
        exp_status.push_back(16'h0103);
        exp_status.push_back(16'h0183);
        exp_status.push_back(16'h02B1);
        exp_mode.push_back(3'd0);
        exp_irq.push_back(1'b0);
        ctrl_in = 6'h06;
        tick();
        tick();
        ctrl_in = 6'h04;
        tick();
        ctrl_in = 6'h06;
        tick();
        tick();
        cop_done  = 1'b1;
        cop_error = 1'b1;
        tick();
        cop_done  = 1'b0;
        cop_error = 1'b0;
        exp_irq.push_back(1'b1);
        tick();
        exp_irq.push_back(1'b0);
        ctrl_in = 6'h00;
        tick();
        exp_irq.push_back(1'b1);
        ctrl_in = 6'h04;
        tick();

        // Reset request mid-RUN coinciding with done: HOLD wins, count cleared.
        exp_status.push_back(16'h0202);
        exp_status.push_back(16'h0203);
        exp_status.push_back(16'h0000);
        exp_status.push_back(16'h0001);
        exp_mode.push_back(3'd0);
        exp_irq.push_back(1'b0);
        exp_rlow.push_back(4);
        ctrl_in = 6'h06;
        repeat (3) tick();
        ctrl_in  = 6'h07;
        cop_done = 1'b1;
        tick();
        cop_done = 1'b0;
        tick();
        tick();
        ctrl_in = 6'h04;
        repeat (6) tick();

        // 257 complete runs: done_count saturates at 0xFF.
        ctrl_in = 6'h00;
        tick();
        for (int i = 0; i < 257; i++) begin
            c  = (i > 255) ? 255 : i;
            c2 = (i + 1 > 255) ? 255 : i + 1;
            exp_status.push_back({c[7:0], 8'h02});
            exp_status.push_back({c[7:0], 8'h03});
            exp_status.push_back({c2[7:0], 8'h11});
            exp_mode.push_back(3'd0);
            ctrl_in = 6'h02;
            tick();
            tick();
            cop_done = 1'b1;
            tick();
            cop_done = 1'b0;
            ctrl_in  = 6'h00;
            tick();
        end

        // Done pulse in IDLE must change nothing.
        cop_done = 1'b1;
        tick();
        cop_done = 1'b0;
        repeat (4) tick();
        check("final_status", 32'(status), 32'hFF11);

        check("status_left", 32'(exp_status.size()), 32'd0);
        check("mode_left", 32'(exp_mode.size()), 32'd0);
        check("rlow_left", 32'(exp_rlow.size()), 32'd0);
        check("irq_left", 32'(exp_irq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
